// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: N-channel, W-bit stream multiplexer with valid/ready
// handshakes on every channel and a single registered output stage.
//
// Two arbitration modes:
//   mode = 0  fixed select. The channel named by sel is granted when it is
//             valid. A sel value of NCH or above grants nothing.
//   mode = 1  round-robin. The search starts at rr_ptr and wraps modulo NCH.
//             After each transfer rr_ptr moves to one past the winner.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   mode       in   1       0 = fixed select, 1 = round-robin
//   sel        in   SW      channel index used in fixed mode
//   in_valid   in   NCH     per-channel valid
//   in_ready   out  NCH     per-channel ready, at most one bit high (combinational)
//   in_data    in   NCH*W   channel i occupies bits [i*W +: W]
//   out_valid  out  1       output register holds a beat
//   out_ready  in   1       consumer accepts the beat
//   out_data   out  W       registered data
//   out_src    out  SW      channel index of the beat in out_data

module mux_nto1_stream #(
    parameter int unsigned NCH = 8,
    parameter int unsigned W   = 32,
    parameter int unsigned SW  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic [NCH-1:0]     in_valid,
    output logic [NCH-1:0]     in_ready,
    input  logic [NCH*W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [SW-1:0]      out_src
);

    // NCH at index width plus one bit, so that comparisons against it cannot overflow.
    localparam logic [SW:0] NCH_EXT = (SW+1)'(NCH);

    logic               r_out_valid;
    logic [W-1:0]       r_out_data;
    logic [SW-1:0]      r_out_src;
    logic [SW-1:0]      r_rr_ptr;

    logic               w_ld;
    logic               w_xfer;
    logic               w_gnt_any;
    logic [SW-1:0]      w_gnt_idx;
    logic [NCH-1:0]     w_gnt;
    logic [W-1:0]       w_gnt_data;
    logic [2*NCH-1:0]   w_rot;
    logic [SW:0]        w_rr_sum;
    logic [SW:0]        w_nxt_sum;
    logic [SW-1:0]      w_nxt_ptr;

    // The output register can accept a beat when it is empty or being drained.
    assign w_ld = !r_out_valid || out_ready;

    // Rotate the valids so that rr_ptr lands at bit 0.
    // The first set bit within the low NCH bits is the round-robin winner.
    assign w_rot = {in_valid, in_valid} >> r_rr_ptr;

    // Grant selection. It produces a single index plus a flag saying the index is live.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_rr_sum  = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = SW'(i);
                end
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (!w_gnt_any && w_rot[k]) begin
                    w_gnt_any = 1'b1;
                    w_rr_sum  = {1'b0, r_rr_ptr} + (SW+1)'(k);
                    if (w_rr_sum >= NCH_EXT) begin
                        w_rr_sum = w_rr_sum - NCH_EXT;
                    end
                    w_gnt_idx = w_rr_sum[SW-1:0];
                end
            end
        end
    end

    // One-hot grant vector and the data of the granted channel.
    always_comb begin
        w_gnt      = '0;
        w_gnt_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (w_gnt_any && w_gnt_idx == SW'(i)) begin
                w_gnt[i]   = 1'b1;
                w_gnt_data = in_data[i*W +: W];
            end
        end
    end

    // While rst is high, ready is gated off so that no producer sees a handshake.
    assign in_ready = w_gnt & {NCH{w_ld && !rst}};
    assign w_xfer   = w_gnt_any && w_ld && !rst;

    // Pointer value that follows the winner, wrapping from NCH-1 back to 0.
    always_comb begin
        w_nxt_sum = {1'b0, w_gnt_idx} + (SW+1)'(1);
        w_nxt_ptr = w_nxt_sum[SW-1:0];
        if (w_nxt_sum >= NCH_EXT) begin
            w_nxt_ptr = '0;
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_src   <= w_gnt_idx;
                if (mode) begin
                    r_rr_ptr <= w_nxt_ptr;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_nto1_stream.sv
module tb_mux_nto1_stream;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;

    // 8-channel instance
    logic            mode;
    logic [SW-1:0]   sel;
    logic [7:0]      in_valid;
    logic [7:0]      in_ready;
    logic [8*W-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;

    // 6-channel instance, used for the out-of-range select case
    logic            mode6;
    logic [SW-1:0]   sel6;
    logic [5:0]      in_valid6;
    logic [5:0]      in_ready6;
    logic [6*W-1:0]  in_data6;
    logic            out_valid6;
    logic            out_ready6;
    logic [W-1:0]    out_data6;
    logic [SW-1:0]   out_src6;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mux_nto1_stream #(.NCH(8), .W(W), .SW(SW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    mux_nto1_stream #(.NCH(6), .W(W), .SW(SW)) dut6 (
        .clk(clk), .rst(rst), .mode(mode6), .sel(sel6),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .out_data(out_data6), .out_src(out_src6)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #4 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL reset_setup out_valid got %b want 1", out_valid);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data);
        else n_pass++;
        n_total++;
        if (out_src !== 3'd0) $display("FAIL reset_out_src got %0d want 0", out_src);
        else n_pass++;
        n_total++;
        if (in_ready !== 8'h00) $display("FAIL reset_in_ready got %b want 0", in_ready);
        else n_pass++;
        #2 rst = 1'b0;
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 8'b0010_0000) $display("FAIL fixed_in_ready got %b want 00100000", in_ready);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 32'h1000_0005 || out_src !== 3'd5)
                $display("FAIL fixed_beat%0d got v=%b d=%h s=%0d want v=1 d=10000005 s=5",
                         c, out_valid, out_data, out_src);
            else n_pass++;
        end
    endtask

    // Covers round-robin order, then backpressure starting from the last held beat (ch7).
    task automatic test_rr_and_backpressure();
        logic [SW-1:0] exp_src [6];
        exp_src = '{3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7};
        do_reset();
        mode = 1'b1; in_valid = 8'b1001_0010; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_src !== exp_src[c] ||
                out_data !== (32'h1000_0000 + 32'(exp_src[c])))
                $display("FAIL rr_beat%0d got v=%b s=%0d d=%h want v=1 s=%0d",
                         c, out_valid, out_src, out_data, exp_src[c]);
            else n_pass++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b1 || out_data !== 32'h1000_0007 || out_src !== 3'd7 ||
                in_ready !== 8'h00)
                $display("FAIL bp_hold%0d got v=%b d=%h s=%0d rdy=%b want v=1 d=10000007 s=7 rdy=0",
                         c, out_valid, out_data, out_src, in_ready);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 8'b0000_0010) $display("FAIL bp_release_ready got %b want 00000010", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 3'd1 || out_data !== 32'h1000_0001)
            $display("FAIL bp_next got v=%b s=%0d d=%h want v=1 s=1 d=10000001", out_valid, out_src, out_data);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 3'd4)
            $display("FAIL bp_follow got v=%b s=%0d want v=1 s=4", out_valid, out_src);
        else n_pass++;
    endtask

    task automatic test_sel_out_of_range();
        do_reset();
        mode6 = 1'b0; sel6 = 3'd2; in_valid6 = 6'h3F; out_ready6 = 1'b1;
        tick();
        n_total++;
        if (out_valid6 !== 1'b1 || out_src6 !== 3'd2 || out_data6 !== 32'h1000_0002)
            $display("FAIL sel6_setup got v=%b s=%0d d=%h want v=1 s=2", out_valid6, out_src6, out_data6);
        else n_pass++;
        sel6 = 3'd6;
        #1;
        n_total++;
        if (in_ready6 !== 6'h00) $display("FAIL sel6_ready got %b want 0", in_ready6);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid6 !== 1'b0) $display("FAIL sel6_drain out_valid got %b want 0", out_valid6);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 1'b1; in_valid = 8'h80; out_ready = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 3'd7)
            $display("FAIL wrap_ch7 got v=%b s=%0d want v=1 s=7", out_valid, out_src);
        else n_pass++;
        in_valid = 8'h81;
        #1;
        n_total++;
        if (in_ready !== 8'h01) $display("FAIL wrap_ready got %b want 00000001", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 32'h1000_0000)
            $display("FAIL wrap_ch0 got v=%b s=%0d d=%h want v=1 s=0 d=10000000", out_valid, out_src, out_data);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        mode = 1'b1; in_valid = 8'b0010_1100; out_ready = 1'b1;
        tick();
        n_total++;
        if (out_src !== 3'd2) $display("FAIL mid_first got %0d want 2", out_src);
        else n_pass++;
        tick();
        n_total++;
        if (out_src !== 3'd3) $display("FAIL mid_ch3 got %0d want 3", out_src);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00)
            $display("FAIL mid_reset got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 8'b0000_0100) $display("FAIL mid_post_ready got %b want 00000100", in_ready);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 3'd2)
            $display("FAIL mid_post_grant got v=%b s=%0d want v=1 s=2", out_valid, out_src);
        else n_pass++;
    endtask

    initial begin
        mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0;
        mode6 = 1'b0; sel6 = '0; in_valid6 = '0; out_ready6 = 1'b0;
        for (int i = 0; i < 8; i++) in_data[i*W +: W] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 6; i++) in_data6[i*W +: W] = 32'h1000_0000 + 32'(i);

        test_reset();
        test_fixed();
        test_rr_and_backpressure();
        test_sel_out_of_range();
        test_wrap();
        test_reset_midstream();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
